uart_rx_word_fifo: RTL and testbench
====================================

# uart_rx_word_fifo

Parametrised UART receiver that samples an asynchronous serial line and assembles `WORD_BYTES` consecutive bytes into one little-endian word. Completed words go into a `FIFO_DEPTH`-entry buffer, which is drained through a standard valid/ready handshake. Optional parity is checked, and framing, parity and overrun errors are reported through sticky flags. The block sits between the board RX pin and the core's input/loader path.

## Interface
- `CLK_PER_HALF_BIT`, 434: clk cycles per half serial bit; must be ≥ 2.
- `WORD_BYTES`, 4: bytes per output word; 1..8.
- `FIFO_DEPTH`, 4: word FIFO entries; power of two, ≥ 2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.

Ports:
- `clk`, in, 1: clock.
- `rstn`, in, 1: reset, synchronous, active-low.
- `rxd`, in, 1: asynchronous serial input, idle high.
- `rdata`, out, 8*WORD_BYTES: FIFO head word; 0 when the FIFO is empty.
- `rdata_valid`, out, 1: FIFO non-empty.
- `rdata_ready`, in, 1: consumer accepts the head word.
- `frame_err`, out, 1: sticky; a stop bit was sampled low.
- `parity_err`, out, 1: sticky; parity mismatch.
- `overrun`, out, 1: sticky; a completed word was dropped because the FIFO was full.
- `err_clear`, in, 1: clears all three sticky flags.
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: number of occupied entries.

## Operation
- Input path:
  - `rxd` passes through a 2-FF synchronizer; `rx_s` is the synchronized value.
  - All sampling uses `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - **IDLE**: waits for `rx_s`=0, then goes to START with the counter at 0. After any STOP, IDLE first requires `rx_s`=1 before arming, so a break does not retrigger.
  - **START**: counts CLK_PER_HALF_BIT−1 cycles, then samples `rx_s`. A value of 1 is a false start: return to IDLE, no error. A value of 0 moves to DATA.
  - **DATA**: samples every 2*CLK_PER_HALF_BIT cycles, i.e. at bit centres. Bits are LSB first into a byte shift register; a 3-bit index counts 8 bits. Then go to PARITY if PARITY≠0, otherwise STOP.
  - **PARITY**: samples one bit. With even parity the XOR of data and parity must be 0; with odd parity it must be 1.
  - **STOP**: samples one bit. A good byte is sampled 1 with no parity error.
- Byte handling:
  - A good byte is written to lane `byte_idx`, at bits [8*byte_idx+7 : 8*byte_idx]. `byte_idx` then increments.
  - When `byte_idx` reaches WORD_BYTES−1 and that byte is good, the assembled word is pushed and `byte_idx` returns to 0.
  - A bad byte sets `frame_err` (stop bit = 0) and/or `parity_err`. The byte is discarded, and the partial word is discarded by setting `byte_idx` to 0.
- FIFO:
  - The FIFO is first-word-fall-through, with wrap-around read and write pointers one bit wider than the address.
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped and `overrun` is set.
  - A pop happens when `rdata_valid && rdata_ready`. A pop while empty is ignored.
  - A simultaneous push and pop leaves `fifo_count` unchanged.
- Sticky flags: if a set and `err_clear` occur in the same cycle, the set wins.
- Reset, synchronous:
  - FSM goes to IDLE; counters and `byte_idx` to 0; FIFO empties.
  - All outputs go to 0: `rdata`, `rdata_valid`, the flags and `fifo_count`.
  - Synchronizer flops reset to 1.
  - Reset mid-frame aborts the frame. The next start is recognized only after `rx_s` has been seen high.

## Timing
- Synchronizer latency: 2 cycles.
- First sample (the start-bit centre) occurs CLK_PER_HALF_BIT cycles after `rx_s` falls. Each following sample is 2*CLK_PER_HALF_BIT cycles after the previous one.
- Sampling instants:
  - A word is pushed on the clock edge of the last byte's stop-bit sample.
  - `rdata_valid` and `rdata` update on the next edge.
  - Error flags assert on the edge after the faulty sample.
- `rdata` holds stable while `rdata_valid`=1 and `rdata_ready`=0.
- With back-to-back pops, the next entry appears the cycle after each pop; full throughput is one word per cycle.
- A frame is 10 bits (11 with parity). The receiver re-arms in IDLE immediately after the stop sample, so it tolerates a stop bit as short as 0.5 bit.

## Test plan
Parameters for the bench: CLK_PER_HALF_BIT=4, WORD_BYTES=4, FIFO_DEPTH=4, PARITY=0, `rdata_ready`=1.

1. Send bytes 0x78, 0x56, 0x34, 0x12 -> exactly one `rdata_valid` pulse with `rdata`=0x12345678. No flags set.
2. Pull `rxd` low for 2 cycles, then high -> FSM returns to IDLE and nothing is pushed. A following 4-byte word 0xDEADBEEF is received correctly.
3. Send 0x11, then 0x22 with stop=0, then 0xAA, 0xBB, 0xCC, 0xDD -> `frame_err`=1. The one word received is 0xDDCCBBAA. `err_clear` returns `frame_err` to 0.
4. With `rdata_ready`=0, send 5 words 1..5 -> `fifo_count`=4, `overrun`=1. Then raise `rdata_ready` -> words 1, 2, 3, 4 pop on consecutive cycles, then `rdata_valid`=0.
5. With PARITY=1 (even), send 0x01 with parity bit 0 -> `parity_err`=1 and the byte is dropped. Send 0x01 with parity bit 1 -> the byte is accepted.
6. Assert `rstn`=0 mid-byte during word 2 -> all outputs are 0. After release, a fresh 4-byte word 0xCAFEF00D is received intact.

Source files
------------

// File: rtl/uart_rx_word_fifo.sv
// UART receiver that packs WORD_BYTES bytes little-endian into words and
// buffers them in a first-word-fall-through FIFO drained by valid/ready.
module uart_rx_word_fifo #(
  parameter int unsigned CLK_PER_HALF_BIT = 434,
  parameter int unsigned WORD_BYTES       = 4,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned PARITY           = 0
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            rxd,
  output logic [8*WORD_BYTES-1:0]         rdata,
  output logic                            rdata_valid,
  input  logic                            rdata_ready,
  output logic                            frame_err,
  output logic                            parity_err,
  output logic                            overrun,
  input  logic                            err_clear,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int unsigned WORD_W = 8 * WORD_BYTES;
  localparam int unsigned CNT_W  = $clog2(2 * CLK_PER_HALF_BIT);
  localparam int unsigned BIDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  START_LAST = CNT_W'(CLK_PER_HALF_BIT - 2);
  localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [BIDX_W-1:0] LAST_BYTE  = BIDX_W'(WORD_BYTES - 1);
  localparam logic [PTR_W-1:0]  DEPTH_CNT  = PTR_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  logic [1:0]        sync_q, sync_d;
  logic              rx_s;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              par_bad_q, par_bad_d;
  logic              armed_q, armed_d;
  logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0] word_q, word_d, word_nx;
  logic              push_q, push_d;
  logic [WORD_W-1:0] push_word_q, push_word_d;
  logic              frame_evt_q, frame_evt_d;
  logic              parity_evt_q, parity_evt_d;

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic              overrun_q, overrun_d;
  logic              pop, full, push_ok;

  always_comb begin
    sync_d = {sync_q[0], rxd};
  end
  assign rx_s = sync_q[1];

  // Receive FSM: start detection, bit-centre sampling and word assembly
  always_comb begin
    state_d      = state_q;
    cnt_d        = CNT_W'(cnt_q + 1'b1);
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    par_bad_d    = par_bad_q;
    armed_d      = armed_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    push_d       = 1'b0;
    push_word_d  = push_word_q;
    frame_evt_d  = 1'b0;
    parity_evt_d = 1'b0;
    word_nx      = word_q;
    word_nx[{byte_idx_q, 3'b000} +: 8] = shreg_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        par_d     = 1'b0;
        par_bad_d = 1'b0;
        if (!armed_q) begin
          if (rx_s) armed_d = 1'b1;
        end else if (!rx_s) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == START_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shreg_d   = {rx_s, shreg_q[7:1]};
          par_d     = par_q ^ rx_s;
          bit_idx_d = 3'(bit_idx_q + 3'd1);
          if (bit_idx_q == 3'd7) begin
            if (PARITY != 0) state_d = ST_PARITY;
            else             state_d = ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_STOP;
          if ((par_q ^ rx_s) != (PARITY == 2)) begin
            par_bad_d    = 1'b1;
            parity_evt_d = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          armed_d = 1'b0;
          if (rx_s && !par_bad_q) begin
            word_d = word_nx;
            if (byte_idx_q == LAST_BYTE) begin
              push_d      = 1'b1;
              push_word_d = word_nx;
              byte_idx_d  = '0;
            end else begin
              byte_idx_d = BIDX_W'(byte_idx_q + 1'b1);
            end
          end else begin
            byte_idx_d  = '0;
            frame_evt_d = !rx_s;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping; a push into a full FIFO only succeeds alongside a pop
  always_comb begin
    pop     = rdata_valid_q && rdata_ready;
    full    = (count_q == DEPTH_CNT);
    push_ok = push_q && (!full || pop);

    wr_ptr_d = push_ok ? PTR_W'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop     ? PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = PTR_W'(count_q + 1'b1);
      2'b01:   count_d = PTR_W'(count_q - 1'b1);
      default: count_d = count_q;
    endcase

    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q[ADDR_W-1:0]] = push_word_q;

    rdata_valid_d = (count_d != '0);
    rdata_d       = rdata_valid_d ? mem_d[rd_ptr_d[ADDR_W-1:0]] : '0;

    frame_err_d  = frame_evt_q  | (frame_err_q  & ~err_clear);
    parity_err_d = parity_evt_q | (parity_err_q & ~err_clear);
    overrun_d    = (push_q && !push_ok) | (overrun_q & ~err_clear);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q        <= 2'b11;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      par_q         <= 1'b0;
      par_bad_q     <= 1'b0;
      armed_q       <= 1'b0;
      byte_idx_q    <= '0;
      word_q        <= '0;
      push_q        <= 1'b0;
      push_word_q   <= '0;
      frame_evt_q   <= 1'b0;
      parity_evt_q  <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      par_q         <= par_d;
      par_bad_q     <= par_bad_d;
      armed_q       <= armed_d;
      byte_idx_q    <= byte_idx_d;
      word_q        <= word_d;
      push_q        <= push_d;
      push_word_q   <= push_word_d;
      frame_evt_q   <= frame_evt_d;
      parity_evt_q  <= parity_evt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      overrun_q     <= overrun_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun     = overrun_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_uart_rx_word_fifo.sv
// Directed plus randomized bench for uart_rx_word_fifo against a byte-level
// reference model of word assembly and FIFO occupancy.
module tb_uart_rx_word_fifo;

  localparam int unsigned HB = 4;
  localparam int unsigned BIT_CYC = 2 * HB;

  logic        clk = 1'b0;
  logic        rstn, rxd, rxd_p, rdata_ready, rdata_ready_p, err_clear;
  logic [31:0] rdata, rdata_p;
  logic        rdata_valid, rdata_valid_p;
  logic        frame_err, parity_err, overrun;
  logic        frame_err_p, parity_err_p, overrun_p;
  logic [2:0]  fifo_count, fifo_count_p;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [31:0] got_q[$];
  int          got_t[$];
  logic [31:0] gotp_q[$];
  logic [31:0] exp_q[$];

  // reference model state
  logic [31:0] m_part;
  int          m_idx;
  int          m_held;
  logic        m_ovr;
  logic        m_fe;

  uart_rx_word_fifo #(.CLK_PER_HALF_BIT(HB), .WORD_BYTES(4), .FIFO_DEPTH(4), .PARITY(0)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .rdata(rdata), .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .err_clear(err_clear), .fifo_count(fifo_count)
  );

  uart_rx_word_fifo #(.CLK_PER_HALF_BIT(HB), .WORD_BYTES(4), .FIFO_DEPTH(4), .PARITY(1)) dut_p (
    .clk(clk), .rstn(rstn), .rxd(rxd_p), .rdata(rdata_p), .rdata_valid(rdata_valid_p),
    .rdata_ready(rdata_ready_p), .frame_err(frame_err_p), .parity_err(parity_err_p),
    .overrun(overrun_p), .err_clear(err_clear), .fifo_count(fifo_count_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record every accepted word; the pop happens on the following rising edge
  always @(negedge clk) begin
    if (rstn && rdata_valid && rdata_ready) begin
      got_q.push_back(rdata);
      got_t.push_back(cyc);
    end
    if (rstn && rdata_valid_p && rdata_ready_p) gotp_q.push_back(rdata_p);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit which, input logic v);
    if (which) rxd_p = v;
    else       rxd   = v;
    idle(BIT_CYC);
  endtask

  // par < 0 means no parity bit; a one-bit idle gap follows every frame
  task automatic send_byte(input bit which, input logic [7:0] d, input logic stop, input int par);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (par >= 0) drive_bit(which, par[0]);
    drive_bit(which, stop);
    drive_bit(which, 1'b1);
  endtask

  task automatic model_word(input logic [31:0] w);
    if (!rdata_ready && m_held >= 4) begin
      m_ovr = 1'b1;
    end else begin
      exp_q.push_back(w);
      if (!rdata_ready) m_held++;
    end
  endtask

  task automatic model_byte(input logic [7:0] d, input bit good);
    if (good) begin
      m_part = m_part | (32'(d) << (8 * m_idx));
      m_idx++;
      if (m_idx == 4) begin
        model_word(m_part);
        m_part = '0;
        m_idx  = 0;
      end
    end else begin
      m_fe   = 1'b1;
      m_part = '0;
      m_idx  = 0;
    end
  endtask

  task automatic byte_both(input logic [7:0] d, input logic stop);
    send_byte(1'b0, d, stop, -1);
    model_byte(d, stop == 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) byte_both(t[8*i +: 8], 1'b1);
  endtask

  task automatic compare_words(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(tag, 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    got_t.delete();
    exp_q.delete();
  endtask

  task automatic pulse_clear;
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    idle(1);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    int         span;
    rstn = 1'b0; rxd = 1'b1; rxd_p = 1'b1; err_clear = 1'b0;
    rdata_ready = 1'b1; rdata_ready_p = 1'b1;
    m_part = '0; m_idx = 0; m_held = 0; m_ovr = 1'b0; m_fe = 1'b0;
    idle(3);
    chk("rst_rdata",  64'(rdata), 64'(0));
    chk("rst_valid",  64'(rdata_valid), 64'(0));
    chk("rst_count",  64'(fifo_count), 64'(0));
    chk("rst_flags",  64'({frame_err, parity_err, overrun}), 64'(0));
    rstn = 1'b1;
    idle(10);

    // 1: single little-endian word
    byte_both(8'h78, 1'b1); byte_both(8'h56, 1'b1);
    byte_both(8'h34, 1'b1); byte_both(8'h12, 1'b1);
    chk("t1_model", 64'(exp_q[0]), 64'h12345678);
    compare_words("t1_word");
    chk("t1_flags", 64'({frame_err, parity_err, overrun}), 64'(0));

    // 2: glitch shorter than half a bit is a false start
    rxd = 1'b0; idle(2); rxd = 1'b1; idle(20);
    chk("t2_nopush", 64'(got_q.size()), 64'(0));
    send_word(32'hDEADBEEF);
    compare_words("t2_word");

    // 3: framing error discards the partial word
    byte_both(8'h11, 1'b1); byte_both(8'h22, 1'b0);
    byte_both(8'hAA, 1'b1); byte_both(8'hBB, 1'b1);
    byte_both(8'hCC, 1'b1); byte_both(8'hDD, 1'b1);
    chk("t3_fe", 64'(frame_err), 64'(m_fe));
    chk("t3_pe", 64'(parity_err), 64'(0));
    compare_words("t3_word");
    pulse_clear();
    m_fe = 1'b0;
    chk("t3_fe_clr", 64'(frame_err), 64'(0));

    // 4: fill with consumer stalled, fifth word overruns
    rdata_ready = 1'b0;
    for (int n = 1; n <= 5; n++) send_word(32'(n));
    chk("t4_count", 64'(fifo_count), 64'(4));
    chk("t4_ovr",   64'(overrun), 64'(m_ovr));
    chk("t4_head",  64'(rdata), 64'(1));
    chk("t4_hold",  64'(got_q.size()), 64'(0));
    rdata_ready = 1'b1;
    m_held = 0;
    idle(10);
    span = (got_t.size() == 4) ? (got_t[3] - got_t[0]) : -1;
    chk("t4_b2b", 64'(span), 64'(3));
    compare_words("t4_words");
    chk("t4_empty", 64'({rdata_valid, rdata}), 64'(0));
    chk("t4_cnt0",  64'(fifo_count), 64'(0));
    pulse_clear();
    m_ovr = 1'b0;
    chk("t4_ovr_clr", 64'(overrun), 64'(0));

    // 5: even parity on the second instance
    send_byte(1'b1, 8'h01, 1'b1, 0);
    chk("t5_pe", 64'(parity_err_p), 64'(1));
    send_byte(1'b1, 8'h01, 1'b1, 1);
    send_byte(1'b1, 8'h02, 1'b1, int'(^8'h02));
    send_byte(1'b1, 8'h03, 1'b1, int'(^8'h03));
    send_byte(1'b1, 8'h04, 1'b1, int'(^8'h04));
    chk("t5_n", 64'(gotp_q.size()), 64'(1));
    if (gotp_q.size() > 0) chk("t5_word", 64'(gotp_q[0]), 64'h04030201);
    chk("t5_fe", 64'(frame_err_p), 64'(0));

    // random byte stream with occasional bad stop bits
    for (int k = 0; k < 14; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      byte_both(rb, rs);
    end
    compare_words("rnd_words");
    chk("rnd_fe", 64'(frame_err), 64'(m_fe));

    // 6: reset mid-byte during the second word
    send_word(32'h11223344);
    byte_both(8'h55, 1'b1);
    rxd = 1'b0; idle(BIT_CYC);
    rxd = 1'b1; idle(BIT_CYC + 3);
    rstn = 1'b0;
    idle(2);
    chk("t6_rst_out", 64'({rdata_valid, frame_err, parity_err, overrun, fifo_count}), 64'(0));
    chk("t6_rst_rdata", 64'(rdata), 64'(0));
    m_part = '0; m_idx = 0; m_fe = 1'b0;
    rxd = 1'b1;
    rstn = 1'b1;
    idle(20);
    send_word(32'hCAFEF00D);
    compare_words("t6_words");
    chk("t6_flags", 64'({frame_err, parity_err, overrun}), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
